vga_rect_renderer: RTL
======================

// Module: vga_rect_renderer
// PURPOSE
//  Parametrised VGA timing generator plus N-rectangle renderer for the iCE40 pong/game designs.
//  Divides the system clock to the pixel rate and produces hsync/vsync/blank.
//  Draws up to NUM_RECTS coloured, prioritised rectangles over a background colour.
//  Rectangle geometry is shadow-registered once per frame so game logic may update it at any time without tearing.
// PARAMETERS
//  CLK_DIV    5    system clocks per pixel (>=1); 100 MHz/5 = 20 MHz
//  H_VIS      400  visible pixels per line
//  H_FP       20   horizontal front porch, pixels
//  H_SYNC     64   horizontal sync width, pixels
//  H_BP       44   horizontal back porch, pixels
//  V_VIS      600  visible lines
//  V_FP       1    vertical front porch, lines
//  V_SYNC     4    vertical sync width, lines
//  V_BP       23   vertical back porch, lines
//  SYNC_POL   1    1: sync pulses high (active-high); 0: pulses low
//  NUM_RECTS  4    number of rectangles (1..8)
//  CW         1    bits per colour channel
// PORTS
//  clk          in   1             system clock
//  rst_n        in   1             asynchronous reset, active low
//  rect_en      in   NUM_RECTS     per-rectangle enable
//  rect_xmin    in   NUM_RECTS*XW  flattened; rect i at [i*XW +: XW], XW=$clog2(H_VIS)
//  rect_xmax    in   NUM_RECTS*XW  inclusive
//  rect_ymin    in   NUM_RECTS*YW  YW=$clog2(V_VIS)
//  rect_ymax    in   NUM_RECTS*YW  inclusive
//  rect_rgb     in   NUM_RECTS*3*CW  {r,g,b} per rect
//  bg_rgb       in   3*CW          background colour
//  hsync        out  1             horizontal sync
//  vsync        out  1             vertical sync
//  blank        out  1             high outside visible area
//  r, g, b      out  CW each       pixel colour, forced 0 while blank
//  frame_start  out  1             one-clk pulse when shadow registers load (start of vblank)
// BEHAVIOUR
//  Reset: hsync=vsync=~SYNC_POL level (inactive), blank=1, r=g=b=0, frame_start=0, counters 0, shadows 0 (all rects disabled).
//  Pixel tick: asserted one clk every CLK_DIV clks; x counter 0..H_TOT-1 wraps, y increments on x wrap, 0..V_TOT-1 wraps.
//  Output stage registered on pixel tick: outputs for (x,y) appear one pixel period after counters equal (x,y); sync/blank/colour share this stage, so they are mutually aligned.
//  hsync active for x in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1]; vsync active for y in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1].
//  blank = (x>=H_VIS)|(y>=V_VIS).
//  Hit i: shadow_en[i] & xmin<=x<=xmax & ymin<=y<=ymax (inclusive). xmin>xmax or ymin>ymax -> never hits.
//  Priority: lowest index hit wins colour; no hit -> bg_rgb (bg is live, not shadowed).
//  Shadow load: on tick where x==H_TOT-1 and y==V_VIS-1 (last tick of last visible line); frame_start pulses same clk. Inputs changed mid-frame take effect next frame only.
//  Async reset mid-frame: all state returns to reset values immediately; frame restarts at (0,0); rects disabled until first shadow load.
//  CLK_DIV==1: tick tied high.
// CONFIGURATION
//  VGA_NET_EN defined: dashed 2-px vertical net at x in {H_VIS/2-1, H_VIS/2}, drawn where y[3]==0, colour white (all ones); priority below all rects, above bg.
//  VGA_NET_EN undefined: no net logic; non-hit pixels show bg_rgb.
// STRUCTURE
//  vga_pkg: default 800x600@60 half-rate timing constants, SYNC_POL values, XW/YW width functions.
//  Sub-module vga_timing_gen: divider, x/y counters, registered sync/blank, tick and frame_start; renderer (hit/priority/shadow) stays in top.
// TESTING
//  Defaults, release rst_n -> first hsync pulse at tick 420 for 64 ticks; line period 528 ticks, frame 628 lines.
//  rect0=(10..19,5..9) white, en=1 -> exactly 50 white visible pixels per frame; all other visible pixels = bg.
//  rect0 and rect1 overlap at (15,7), rect0 red, rect1 blue -> pixel (15,7) red.
//  Change rect0 xmin from 10 to 100 at line 300 -> current frame unchanged; next frame starts at x=100; frame_start pulses once per frame.
//  Assert rst_n low at line 200 for 3 clks -> outputs reset values immediately; next hsync pulse starts 420 ticks after release.
//  With VGA_NET_EN, no rects, bg=0 -> x=199,200 white on y=0..7, black y=8..15; without macro all black.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: default 800x600@60 half-rate timing constants, sync polarity values
// and width helpers shared by the VGA renderer files.
package vga_pkg;

    localparam int DEF_CLK_DIV = 5;
    localparam int DEF_H_VIS   = 400;
    localparam int DEF_H_FP    = 20;
    localparam int DEF_H_SYNC  = 64;
    localparam int DEF_H_BP    = 44;
    localparam int DEF_V_VIS   = 600;
    localparam int DEF_V_FP    = 1;
    localparam int DEF_V_SYNC  = 4;
    localparam int DEF_V_BP    = 23;

    localparam bit SYNC_HIGH = 1'b1;
    localparam bit SYNC_LOW  = 1'b0;

    function automatic int xw(input int h_vis);
        return (h_vis > 1) ? $clog2(h_vis) : 1;
    endfunction

    function automatic int yw(input int v_vis);
        return (v_vis > 1) ? $clog2(v_vis) : 1;
    endfunction

    function automatic int cnt_w(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-rate divider, x/y raster counters and registered sync/blank.
// frame_start marks the last tick of the last visible line, when shadows load.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_VIS    = DEF_H_VIS,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_VIS    = DEF_V_VIS,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = SYNC_HIGH,
    parameter int HCW      = cnt_w(H_VIS + H_FP + H_SYNC + H_BP),
    parameter int VCW      = cnt_w(V_VIS + V_FP + V_SYNC + V_BP)
) (
    input  logic           clk,
    input  logic           rst_n,
    output logic           tick,
    output logic [HCW-1:0] x,
    output logic [VCW-1:0] y,
    output logic           hsync,
    output logic           vsync,
    output logic           blank,
    output logic           frame_start
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    logic x_end;
    logic y_end;
    logic hs_on;
    logic vs_on;

    generate
        if (CLK_DIV == 1) begin : g_nodiv
            assign tick = 1'b1;
        end else begin : g_div
            localparam int DW = $clog2(CLK_DIV);
            logic [DW-1:0] cnt;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) cnt <= '0;
                else        cnt <= (cnt == DW'(CLK_DIV - 1)) ? '0 : cnt + 1'b1;
            end
            assign tick = (cnt == DW'(CLK_DIV - 1));
        end
    endgenerate

    assign x_end = (x == HCW'(H_TOT - 1));
    assign y_end = (y == VCW'(V_TOT - 1));
    assign hs_on = (x >= HCW'(H_VIS + H_FP)) && (x <= HCW'(H_VIS + H_FP + H_SYNC - 1));
    assign vs_on = (y >= VCW'(V_VIS + V_FP)) && (y <= VCW'(V_VIS + V_FP + V_SYNC - 1));
    assign frame_start = tick && x_end && (y == VCW'(V_VIS - 1));

    // sync/blank are registered on the tick so they line up with the colour stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x     <= '0;
            y     <= '0;
            hsync <= ~SYNC_POL;
            vsync <= ~SYNC_POL;
            blank <= 1'b1;
        end else if (tick) begin
            x     <= x_end ? '0 : x + 1'b1;
            y     <= x_end ? (y_end ? '0 : y + 1'b1) : y;
            hsync <= hs_on ? SYNC_POL : ~SYNC_POL;
            vsync <= vs_on ? SYNC_POL : ~SYNC_POL;
            blank <= (x >= HCW'(H_VIS)) || (y >= VCW'(V_VIS));
        end
    end

endmodule

// File: rtl/vga_rect_renderer.sv
// vga_rect_renderer: VGA timing plus NUM_RECTS prioritised, frame-shadowed rectangles
// over a live background; define VGA_NET_EN to add a dashed centre net.
module vga_rect_renderer
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int H_VIS     = DEF_H_VIS,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VIS     = DEF_V_VIS,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter bit SYNC_POL  = SYNC_HIGH,
    parameter int NUM_RECTS = 4,
    parameter int CW        = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_RECTS-1:0]          rect_en,
    input  logic [NUM_RECTS*xw(H_VIS)-1:0] rect_xmin,
    input  logic [NUM_RECTS*xw(H_VIS)-1:0] rect_xmax,
    input  logic [NUM_RECTS*yw(V_VIS)-1:0] rect_ymin,
    input  logic [NUM_RECTS*yw(V_VIS)-1:0] rect_ymax,
    input  logic [NUM_RECTS*3*CW-1:0]     rect_rgb,
    input  logic [3*CW-1:0]               bg_rgb,
    output logic                          hsync,
    output logic                          vsync,
    output logic                          blank,
    output logic [CW-1:0]                 r,
    output logic [CW-1:0]                 g,
    output logic [CW-1:0]                 b,
    output logic                          frame_start
);

    localparam int XW  = xw(H_VIS);
    localparam int YW  = yw(V_VIS);
    localparam int HCW = cnt_w(H_VIS + H_FP + H_SYNC + H_BP);
    localparam int VCW = cnt_w(V_VIS + V_FP + V_SYNC + V_BP);

    logic           tick;
    logic [HCW-1:0] x;
    logic [VCW-1:0] y;

    logic [NUM_RECTS-1:0]      sh_en;
    logic [NUM_RECTS*XW-1:0]   sh_xmin;
    logic [NUM_RECTS*XW-1:0]   sh_xmax;
    logic [NUM_RECTS*YW-1:0]   sh_ymin;
    logic [NUM_RECTS*YW-1:0]   sh_ymax;
    logic [NUM_RECTS*3*CW-1:0] sh_rgb;

    logic [NUM_RECTS-1:0] hit;
    logic [3*CW-1:0]      base;
    logic [3*CW-1:0]      pix;
    logic                 visible;

    vga_timing_gen #(
        .CLK_DIV  (CLK_DIV),
        .H_VIS    (H_VIS),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_VIS    (V_VIS),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .SYNC_POL (SYNC_POL),
        .HCW      (HCW),
        .VCW      (VCW)
    ) u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .x           (x),
        .y           (y),
        .hsync       (hsync),
        .vsync       (vsync),
        .blank       (blank),
        .frame_start (frame_start)
    );

    // geometry and colours load once per frame so game logic never tears a frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_en   <= '0;
            sh_xmin <= '0;
            sh_xmax <= '0;
            sh_ymin <= '0;
            sh_ymax <= '0;
            sh_rgb  <= '0;
        end else if (frame_start) begin
            sh_en   <= rect_en;
            sh_xmin <= rect_xmin;
            sh_xmax <= rect_xmax;
            sh_ymin <= rect_ymin;
            sh_ymax <= rect_ymax;
            sh_rgb  <= rect_rgb;
        end
    end

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_RECTS; i++)
            hit[i] = sh_en[i]
                && (x >= HCW'(sh_xmin[i*XW +: XW])) && (x <= HCW'(sh_xmax[i*XW +: XW]))
                && (y >= VCW'(sh_ymin[i*YW +: YW])) && (y <= VCW'(sh_ymax[i*YW +: YW]));
    end

`ifdef VGA_NET_EN
    assign base = (((x == HCW'(H_VIS/2 - 1)) || (x == HCW'(H_VIS/2))) && !y[3]) ? '1 : bg_rgb;
`else
    assign base = bg_rgb;
`endif

    // walk from the highest index down so the lowest-index hit is written last
    always_comb begin
        pix = base;
        for (int i = NUM_RECTS - 1; i >= 0; i--)
            if (hit[i]) pix = sh_rgb[i*3*CW +: 3*CW];
    end

    assign visible = (x < HCW'(H_VIS)) && (y < VCW'(V_VIS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    {r, g, b} <= '0;
        else if (tick) {r, g, b} <= visible ? pix : '0;
    end

endmodule
